alu_pipe_issue_ctrl: RTL and testbench

Issue controller for the team's 4-stage register-file ALU pipeline (operand fetch, ALU, register write-back, memory store). It buffers incoming instructions in a small in-order queue. A scoreboard tracks destination registers still in flight, and the block holds back any instruction whose source operand has not yet been written back (RAW hazard). Instructions are issued one per cycle in program order, so the pipeline never reads a stale register-bank value.

---
 rtl/alu_pipe_issue_ctrl.sv | 90 +++++++++
 tb/tb_alu_pipe_issue_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/alu_pipe_issue_ctrl.sv
// alu_pipe_issue_ctrl: in-order issue queue with a RAW scoreboard for the 4-stage ALU pipeline
module alu_pipe_issue_ctrl #(
    parameter int DEPTH  = 4,
    parameter int WB_LAT = 3
) (
    input  logic        clk1,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_rs1,
    input  logic [3:0]  in_rs2,
    input  logic [3:0]  in_rd,
    input  logic [3:0]  in_func,
    input  logic [7:0]  in_addr,
    input  logic        hold,
    output logic        iss_valid,
    output logic [3:0]  iss_rs1,
    output logic [3:0]  iss_rs2,
    output logic [3:0]  iss_rd,
    output logic [3:0]  iss_func,
    output logic [7:0]  iss_addr,
    output logic        busy,
    output logic [15:0] stall_cnt
);
    localparam int AW = $clog2(DEPTH);
    logic [23:0]       mem_q [DEPTH];
    logic [23:0]       mem_d [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic [WB_LAT-1:0] sb_v_q, sb_v_d;
    logic [3:0]        sb_rd_q [WB_LAT];
    logic [3:0]        sb_rd_d [WB_LAT];
    logic [23:0]       iss_q, iss_d;
    logic              iss_valid_q, iss_valid_d;
    logic [15:0]       stall_q, stall_d;
    logic [23:0]       head;
    logic              accept, issue, hazard, nonempty;
    always_comb begin
        head = mem_q[rd_ptr_q];
        nonempty = count_q != '0;
        hazard = 1'b0;
        // The oldest entry is written back on this very edge, so it no longer blocks.
        for (int i = 0; i < WB_LAT - 1; i++)
            hazard = hazard | (sb_v_q[i] && (sb_rd_q[i] == head[23:20] || sb_rd_q[i] == head[19:16]));
        in_ready = !rst && count_q != (AW+1)'(DEPTH);
        accept = in_valid && in_ready;
        issue = nonempty && !hold && !hazard;
        mem_d = mem_q;
        if (accept)
            mem_d[wr_ptr_q] = {in_rs1, in_rs2, in_rd, in_func, in_addr};
        wr_ptr_d = wr_ptr_q + AW'(accept);
        rd_ptr_d = rd_ptr_q + AW'(issue);
        count_d = count_q + (AW+1)'(accept) - (AW+1)'(issue);
        sb_v_d = WB_LAT'({sb_v_q, issue});
        sb_rd_d = sb_rd_q;
        sb_rd_d[0] = head[15:12];
        for (int i = 1; i < WB_LAT; i++)
            sb_rd_d[i] = sb_rd_q[i-1];
        iss_valid_d = issue;
        iss_d = issue ? head : iss_q;
        stall_d = (nonempty && !hold && hazard && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
    end
    always_ff @(posedge clk1) begin
        if (rst) begin
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            sb_v_q      <= '0;
            sb_rd_q     <= '{default: '0};
            iss_q       <= '0;
            iss_valid_q <= 1'b0;
            stall_q     <= '0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            sb_v_q      <= sb_v_d;
            sb_rd_q     <= sb_rd_d;
            iss_q       <= iss_d;
            iss_valid_q <= iss_valid_d;
            stall_q     <= stall_d;
        end
    end
    assign iss_valid = iss_valid_q;
    assign {iss_rs1, iss_rs2, iss_rd, iss_func, iss_addr} = iss_q;
    assign busy = nonempty || (|sb_v_q);
    assign stall_cnt = stall_q;
endmodule

// File: tb/tb_alu_pipe_issue_ctrl.sv
// tb_alu_pipe_issue_ctrl: directed vectors with a queue-based scoreboard for alu_pipe_issue_ctrl
module tb_alu_pipe_issue_ctrl;
    logic        clk1 = 1'b0;
    logic        rst, in_valid, hold;
    logic        in_ready, iss_valid, busy;
    logic [3:0]  in_rs1, in_rs2, in_rd, in_func;
    logic [3:0]  iss_rs1, iss_rs2, iss_rd, iss_func;
    logic [7:0]  in_addr, iss_addr;
    logic [15:0] stall_cnt;
    int          cyc = 0;
    int          n_chk = 0;
    int          errs = 0;
    int          t;
    logic [23:0] acc [4];
    typedef struct {
        logic [23:0] f;
        int          c;
    } exp_t;
    exp_t        sbq[$];
    exp_t        e;

    alu_pipe_issue_ctrl dut (
        .clk1(clk1), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_func(in_func), .in_addr(in_addr),
        .hold(hold), .iss_valid(iss_valid),
        .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd), .iss_func(iss_func), .iss_addr(iss_addr),
        .busy(busy), .stall_cnt(stall_cnt)
    );

    always #5 clk1 = ~clk1;
    always @(posedge clk1) cyc <= cyc + 1;

    // Monitor: every issue pulse must match the oldest expected entry, on the expected edge.
    always @(negedge clk1) begin
        if (sbq.size() != 0 && sbq[0].c < cyc) begin
            n_chk++;
            errs++;
            e = sbq.pop_front();
            $display("FAIL missed_issue: nothing issued at edge %0d, required %h", e.c, e.f);
        end
        if (iss_valid === 1'b1) begin
            n_chk++;
            if (sbq.size() == 0) begin
                errs++;
                $display("FAIL unexpected_issue: got %h at edge %0d, required no issue",
                         {iss_rs1, iss_rs2, iss_rd, iss_func, iss_addr}, cyc);
            end else begin
                e = sbq.pop_front();
                if ({iss_rs1, iss_rs2, iss_rd, iss_func, iss_addr} !== e.f || cyc != e.c) begin
                    errs++;
                    $display("FAIL issue: got %h at edge %0d, required %h at edge %0d",
                             {iss_rs1, iss_rs2, iss_rd, iss_func, iss_addr}, cyc, e.f, e.c);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_chk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // lat < 0: the instruction is expected never to issue.
    task automatic offer(input logic [3:0] a, input logic [3:0] b, input logic [3:0] d,
                         input logic [3:0] f, input logic [7:0] ad, input int lat);
        {in_rs1, in_rs2, in_rd, in_func, in_addr} = {a, b, d, f, ad};
        in_valid = 1'b1;
        chk("offer_in_ready", in_ready, 1);
        if (lat >= 0)
            sbq.push_back('{f: {a, b, d, f, ad}, c: cyc + lat});
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b1;
        hold = 1'b0;
        {in_rs1, in_rs2, in_rd, in_func, in_addr} = 24'h12345A;
        repeat (2) step();
        chk("reset_in_ready", in_ready, 0);
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("post_reset_in_ready", in_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_stall", stall_cnt, 0);
        chk("reset_iss_valid", iss_valid, 0);
        chk("reset_iss_fields", {iss_rs1, iss_rs2, iss_rd, iss_func, iss_addr}, 0);
        repeat (3) step();
        chk("reset_nothing_accepted", busy, 0);

        offer(4'd7, 4'd2, 4'd9, 4'd0, 8'h00, 2);
        offer(4'd5, 4'd6, 4'd10, 4'd1, 8'h01, 2);
        repeat (5) step();
        chk("indep_stall", stall_cnt, 0);

        t = cyc;
        offer(4'd1, 4'd2, 4'd9, 4'd0, 8'h00, 2);
        offer(4'd9, 4'd3, 4'd10, 4'd3, 8'h00, 4);
        while (cyc < t + 7) step();
        chk("raw_busy_before_drain", busy, 1);
        step();
        chk("raw_busy_after_drain", busy, 0);
        chk("raw_stall", stall_cnt, 2);
        repeat (3) step();

        hold = 1'b1;
        for (int i = 0; i < 6; i++) begin
            {in_rs1, in_rs2, in_rd, in_func, in_addr} = {4'(i), 4'(i), 4'(8 + i), 4'(i), 8'(8'h40 + i)};
            in_valid = 1'b1;
            chk("full_in_ready", in_ready, (i < 4) ? 1 : 0);
            if (i < 4)
                acc[i] = {in_rs1, in_rs2, in_rd, in_func, in_addr};
            step();
        end
        in_valid = 1'b0;
        chk("full_busy", busy, 1);
        hold = 1'b0;
        t = cyc;
        for (int j = 0; j < 4; j++)
            sbq.push_back('{f: acc[j], c: t + 1 + j});
        step();
        chk("full_ready_returns", in_ready, 1);
        repeat (3) step();
        offer(4'd1, 4'd1, 4'd12, 4'd5, 8'h50, 2);
        offer(4'd2, 4'd2, 4'd13, 4'd6, 8'h51, 2);
        offer(4'd3, 4'd3, 4'd14, 4'd7, 8'h52, 2);
        repeat (5) step();
        chk("wrap_stall", stall_cnt, 2);

        offer(4'd4, 4'd4, 4'd5, 4'd2, 8'h10, 2);
        offer(4'd5, 4'd0, 4'd6, 4'd4, 8'h11, 7);
        hold = 1'b1;
        repeat (5) step();
        hold = 1'b0;
        repeat (5) step();
        chk("hold_stall_unchanged", stall_cnt, 2);

        offer(4'd1, 4'd1, 4'd7, 4'd8, 8'h20, 2);
        offer(4'd7, 4'd0, 4'd8, 4'd9, 8'h21, -1);
        offer(4'd0, 4'd7, 4'd11, 4'd9, 8'h22, -1);
        offer(4'd7, 4'd7, 4'd12, 4'd9, 8'h23, -1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_stall", stall_cnt, 0);
        chk("midrst_iss_valid", iss_valid, 0);
        chk("midrst_iss_fields", {iss_rs1, iss_rs2, iss_rd, iss_func, iss_addr}, 0);
        repeat (4) step();
        chk("midrst_still_idle", busy, 0);
        offer(4'd7, 4'd7, 4'd9, 4'd1, 8'h30, 2);
        repeat (4) step();
        chk("midrst_fresh_stall", stall_cnt, 0);

        repeat (6) step();
        chk("scoreboard_drained", 24'(sbq.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, errs);
        $finish;
    end
endmodule
